// File: rtl/sram_grid_pkg.sv
// Shared types and constants for the SRAM grid sampler and its colour helpers.
package sram_grid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACC,
        OUT,
        DONE
    } state_t;

    localparam int R_HI = 15;
    localparam int R_LO = 11;
    localparam int G_HI = 10;
    localparam int G_LO = 5;
    localparam int B_HI = 4;
    localparam int B_LO = 0;

    // True when every sample (plus its averaging neighbour) lies inside the frame
    // and the index/address widths can represent the grid and the frame.
    function automatic bit grid_cfg_ok(
        input int h_max,
        input int v_max,
        input int grid,
        input int h_start,
        input int v_start,
        input int h_step,
        input int v_step,
        input int avg_en,
        input int rd_lat,
        input int idx_w,
        input int addr_w
    );
        return (grid >= 1) && (grid <= 15) && (rd_lat >= 1) && (rd_lat <= 4)
            && (h_start + (grid - 1) * h_step + avg_en < h_max)
            && (v_start + (grid - 1) * v_step + avg_en < v_max)
            && (longint'(grid * grid) < (longint'(1) << idx_w))
            && (longint'(h_max) * longint'(v_max) <= (longint'(1) << addr_w));
    endfunction

endpackage

// File: rtl/rgb565_avg4.sv
// Per-channel RGB565 accumulator over four pixels; result is each sum >> 2 (truncated).
// Sums update one cycle after add; clr has priority over add.
module rgb565_avg4
    import sram_grid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] pix_in,
    output logic [15:0] rgb_out
);

    logic [6:0] r_rsum;
    logic [7:0] r_gsum;
    logic [6:0] r_bsum;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_rsum <= '0;
            r_gsum <= '0;
            r_bsum <= '0;
        end else if (add) begin
            r_rsum <= r_rsum + {2'b00, pix_in[R_HI:R_LO]};
            r_gsum <= r_gsum + {2'b00, pix_in[G_HI:G_LO]};
            r_bsum <= r_bsum + {2'b00, pix_in[B_HI:B_LO]};
        end
    end

    assign rgb_out = {r_rsum[6:2], r_gsum[7:2], r_bsum[6:2]};

endmodule

// File: rtl/sram_grid_sampler.sv
// Fetches a GRID x GRID lattice of pixels from frame SRAM, one read outstanding at a time,
// (2+RD_LAT) cycles per read; each sample is held on out_valid until out_ready.
module sram_grid_sampler
    import sram_grid_pkg::*;
#(
    parameter int H_MAX   = 320,
    parameter int V_MAX   = 240,
    parameter int GRID    = 3,
    parameter int H_START = 40,
    parameter int V_START = 40,
    parameter int H_STEP  = 80,
    parameter int V_STEP  = 80,
    parameter int AVG_EN  = 0,
    parameter int RD_LAT  = 1,
    parameter int ADDR_W  = 19,
    parameter int IDX_W   = 8
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              sram_sel,
    output logic              sram_we,
    output logic              sram_rd,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [15:0]       sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       rgb565,
    output logic [IDX_W-1:0]  position_coding,
    output logic              done
);

    if (!grid_cfg_ok(H_MAX, V_MAX, GRID, H_START, V_START, H_STEP, V_STEP,
                     AVG_EN, RD_LAT, IDX_W, ADDR_W)) begin : g_bad_cfg
        $error("sram_grid_sampler: sample lattice does not fit the frame or index width");
    end

    localparam logic [ADDR_W-1:0] ROW0     = ADDR_W'(V_START * H_MAX);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(V_STEP * H_MAX);
    localparam logic [ADDR_W-1:0] COL0     = ADDR_W'(H_START);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(H_STEP);
    localparam logic [ADDR_W-1:0] PITCH    = ADDR_W'(H_MAX);
    localparam logic [3:0]        G_LAST   = 4'(GRID - 1);
    localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);

    state_t             r_state;
    logic [3:0]         r_gx;
    logic [3:0]         r_gy;
    logic [1:0]         r_k;
    logic [1:0]         r_lat;
    logic [ADDR_W-1:0]  r_row_base;
    logic [ADDR_W-1:0]  r_col_off;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_pix;
    logic [15:0]        r_rgb;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_pos;
    logic               r_busy;
    logic               r_rd;
    logic               r_valid;
    logic               r_done;

    logic [1:0]         w_k_nxt;
    logic [ADDR_W-1:0]  w_sub_off;
    logic [ADDR_W-1:0]  w_pt_addr;
    logic [ADDR_W-1:0]  w_sub_addr;
    logic               w_last_col;
    logic               w_last_pt;
    logic [ADDR_W-1:0]  w_nx_col;
    logic [ADDR_W-1:0]  w_nx_row;
    logic [ADDR_W-1:0]  w_next_addr;
    logic               w_acc_clr;
    logic               w_acc_add;
    logic [15:0]        w_avg_rgb;

    // Sub-read k of a point walks the 2x2 block: +0, +1, +H_MAX, +H_MAX+1.
    always_comb begin
        w_k_nxt = r_k + 2'd1;
        case (w_k_nxt)
            2'd1:    w_sub_off = ADDR_W'(1);
            2'd2:    w_sub_off = PITCH;
            2'd3:    w_sub_off = PITCH + ADDR_W'(1);
            default: w_sub_off = '0;
        endcase
    end

    assign w_pt_addr   = r_row_base + r_col_off;
    assign w_sub_addr  = w_pt_addr + w_sub_off;
    assign w_last_col  = (r_gx == G_LAST);
    assign w_last_pt   = w_last_col && (r_gy == G_LAST);
    assign w_nx_col    = w_last_col ? COL0 : (r_col_off + COL_STEP);
    assign w_nx_row    = w_last_col ? (r_row_base + ROW_STEP) : r_row_base;
    assign w_next_addr = w_nx_row + w_nx_col;

    assign w_acc_clr = ((r_state == IDLE) && start)
                    || ((r_state == OUT) && out_ready && !w_last_pt);
    assign w_acc_add = (AVG_EN != 0) && (r_state == ACC);

    rgb565_avg4 u_avg (
        .clk     (wclk),
        .rst     (rst),
        .clr     (w_acc_clr),
        .add     (w_acc_add),
        .pix_in  (r_pix),
        .rgb_out (w_avg_rgb)
    );

    always_ff @(posedge wclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gx       <= '0;
            r_gy       <= '0;
            r_k        <= '0;
            r_lat      <= '0;
            r_row_base <= '0;
            r_col_off  <= '0;
            r_addr     <= '0;
            r_pix      <= '0;
            r_rgb      <= '0;
            r_idx      <= '0;
            r_pos      <= '0;
            r_busy     <= 1'b0;
            r_rd       <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rd   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= ISSUE;
                        r_busy     <= 1'b1;
                        r_gx       <= '0;
                        r_gy       <= '0;
                        r_k        <= '0;
                        r_idx      <= IDX_W'(1);
                        r_row_base <= ROW0;
                        r_col_off  <= COL0;
                        r_addr     <= ROW0 + COL0;
                        r_rd       <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                    r_lat   <= '0;
                end
                WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_pix   <= sram_rdata;
                        r_state <= ACC;
                    end else begin
                        r_lat <= r_lat + 2'd1;
                    end
                end
                ACC: begin
                    if ((AVG_EN != 0) && (r_k != 2'd3)) begin
                        r_k     <= w_k_nxt;
                        r_addr  <= w_sub_addr;
                        r_rd    <= 1'b1;
                        r_state <= ISSUE;
                    end else begin
                        r_rgb   <= r_pix;
                        r_pos   <= r_idx;
                        r_valid <= 1'b1;
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (w_last_pt) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_gx       <= w_last_col ? 4'd0 : (r_gx + 4'd1);
                            r_gy       <= w_last_col ? (r_gy + 4'd1) : r_gy;
                            r_col_off  <= w_nx_col;
                            r_row_base <= w_nx_row;
                            r_k        <= '0;
                            r_idx      <= r_idx + IDX_W'(1);
                            r_addr     <= w_next_addr;
                            r_rd       <= 1'b1;
                            r_state    <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign sram_sel        = r_rd;
    assign sram_rd         = r_rd;
    assign sram_we         = 1'b0;
    assign sram_addr       = r_addr;
    assign out_valid       = r_valid;
    assign rgb565          = (AVG_EN != 0) ? w_avg_rgb : r_rgb;
    assign position_coding = r_pos;
    assign done            = r_done;

endmodule

// File: tb/tb_sram_grid_sampler.sv
// Drives four sampler configurations against a latency-accurate SRAM model and
// compares every read address and sample with a reference computed from frame geometry.
module tb_sram_grid_sampler;

    localparam int NI    = 4;
    localparam int H_MAX = 320;

    function automatic int cfg_grid(input int i);
        return (i == 2) ? 4 : ((i == 3) ? 1 : 3);
    endfunction
    function automatic int cfg_start(input int i);
        return (i == 2) ? 50 : 40;
    endfunction
    function automatic int cfg_step(input int i);
        return (i == 2) ? 50 : 80;
    endfunction
    function automatic int cfg_avg(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int cfg_lat(input int i);
        return (i == 1) ? 3 : ((i == 3) ? 2 : 1);
    endfunction

    logic wclk = 1'b0;
    always #5 wclk = ~wclk;

    logic                  rst;
    logic [NI-1:0]         start;
    logic [NI-1:0]         out_ready;
    logic [NI-1:0]         busy;
    logic [NI-1:0]         sel;
    logic [NI-1:0]         we;
    logic [NI-1:0]         rd;
    logic [NI-1:0]         valid;
    logic [NI-1:0]         done;
    logic [NI-1:0][18:0]   addr;
    logic [NI-1:0][15:0]   rgb;
    logic [NI-1:0][7:0]    pos;

    int n_vec = 0;
    int n_err = 0;
    int seed;
    int cur = 0;
    int done_cnt = 0;
    logic rd_prev = 1'b0;
    logic [18:0] rd_q [$];
    logic [15:0] ovr [int];

    // Frame content: pseudo-random per address, with explicit overrides where a test needs them.
    function automatic logic [15:0] pix(input int a);
        if (ovr.exists(a)) return ovr[a];
        return 16'(((a * 32'h9E3779B1) ^ seed) >>> 9);
    endfunction

    function automatic logic [15:0] exp_rgb(input int i, input int h, input int v);
        int rs, gs, bs;
        logic [15:0] px;
        if (cfg_avg(i) == 0) return pix(v * H_MAX + h);
        rs = 0; gs = 0; bs = 0;
        for (int k = 0; k < 4; k++) begin
            px = pix((v + k / 2) * H_MAX + h + k % 2);
            rs += int'(px[15:11]);
            gs += int'(px[10:5]);
            bs += int'(px[4:0]);
        end
        return {5'(rs / 4), 6'(gs / 4), 5'(bs / 4)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = cfg_lat(g);
        logic [15:0] rdata_g;
        logic [19:0] pipe [4];

        sram_grid_sampler #(
            .GRID    (cfg_grid(g)),
            .H_START (cfg_start(g)),
            .V_START (cfg_start(g)),
            .H_STEP  (cfg_step(g)),
            .V_STEP  (cfg_step(g)),
            .AVG_EN  (cfg_avg(g)),
            .RD_LAT  (LAT)
        ) u_dut (
            .wclk            (wclk),
            .rst             (rst),
            .start           (start[g]),
            .busy            (busy[g]),
            .sram_sel        (sel[g]),
            .sram_we         (we[g]),
            .sram_rd         (rd[g]),
            .sram_addr       (addr[g]),
            .sram_rdata      (rdata_g),
            .out_valid       (valid[g]),
            .out_ready       (out_ready[g]),
            .rgb565          (rgb[g]),
            .position_coding (pos[g]),
            .done            (done[g])
        );

        always @(posedge wclk) begin
            pipe[0] <= {rd[g], addr[g]};
            for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
        end

        // Data is valid only in the cycle LAT after the strobe; garbage otherwise.
        always @(posedge wclk) begin
            #1;
            rdata_g = pipe[LAT-1][19] ? pix(int'(pipe[LAT-1][18:0])) : 16'($urandom);
        end
    end

    always @(negedge wclk) begin
        if (rd[cur] || sel[cur]) begin
            chk("sel_eq_rd", 64'(sel[cur]), 64'(rd[cur]));
            chk("strobe_1cyc", 64'(rd_prev), 64'd0);
        end
        if (rd[cur]) rd_q.push_back(addr[cur]);
        if (done[cur]) done_cnt++;
        rd_prev = rd[cur];
    end

    task automatic run_pass(input int i, input int bp_pos, input int rst_pos,
                            input bit dbl_start, input bit start_done, input bit rnd_stall);
        int gr, lat, nrd, cyc, h, v, stall, base_done;
        logic [15:0] erg;
        logic [63:0] got;
        gr = cfg_grid(i);
        lat = cfg_lat(i);
        nrd = (cfg_avg(i) != 0) ? 4 : 1;
        cur = i;
        rd_q.delete();
        base_done = done_cnt;
        @(posedge wclk); #1 start[i] = 1'b1;
        @(posedge wclk); #1 start[i] = 1'b0;
        for (int p = 0; p < gr * gr; p++) begin
            h = cfg_start(i) + (p % gr) * cfg_step(i);
            v = cfg_start(i) + (p / gr) * cfg_step(i);
            erg = exp_rgb(i, h, v);
            cyc = 0;
            do begin
                @(negedge wclk);
                cyc++;
                start[i] = (dbl_start && p == 1 && cyc == 1);
            end while (!valid[i] && cyc < 200);
            chk("latency", 64'(cyc), 64'(nrd * (2 + lat) + 1));
            if (cyc >= 200) return;
            chk("busy", 64'(busy[i]), 64'd1);
            chk("we", 64'(we[i]), 64'd0);
            chk("pos", 64'(pos[i]), 64'(p + 1));
            chk("rgb", 64'(rgb[i]), 64'(erg));
            if (i == 1 && p == 0) chk("avg_block", 64'(rgb[i]), 64'h7BEF);
            chk("nreads", 64'(rd_q.size()), 64'(nrd));
            for (int k = 0; k < nrd; k++) begin
                got = (k < rd_q.size()) ? 64'(rd_q[k]) : '1;
                chk("addr", got, 64'((v + k / 2) * H_MAX + h + k % 2));
            end
            rd_q.delete();
            if (rst_pos == p + 1) begin
                out_ready[i] = 1'b0;
                @(posedge wclk); #1 rst = 1'b1;
                @(posedge wclk); #1 rst = 1'b0;
                @(negedge wclk);
                chk("rst_outputs", 64'({busy[i], sel[i], we[i], rd[i], addr[i], valid[i],
                                        rgb[i], pos[i], done[i]}), 64'd0);
                out_ready[i] = 1'b1;
                repeat (8) @(negedge wclk);
                chk("rst_no_done", 64'(done_cnt - base_done), 64'd0);
                chk("rst_idle", 64'({busy[i], valid[i]}), 64'd0);
                return;
            end
            stall = (bp_pos == p + 1) ? 10 : (rnd_stall ? int'($urandom_range(0, 3)) : 0);
            if (stall > 0) begin
                out_ready[i] = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    @(negedge wclk);
                    chk("bp_valid", 64'(valid[i]), 64'd1);
                    chk("bp_pos", 64'(pos[i]), 64'(p + 1));
                    chk("bp_rgb", 64'(rgb[i]), 64'(erg));
                    chk("bp_nostrobe", 64'(rd[i]), 64'd0);
                end
                out_ready[i] = 1'b1;
            end
        end
        @(negedge wclk);
        chk("done_pulse", 64'(done[i]), 64'd1);
        chk("valid_drop", 64'(valid[i]), 64'd0);
        if (start_done) start[i] = 1'b1;
        @(negedge wclk);
        start[i] = 1'b0;
        chk("done_clear", 64'(done[i]), 64'd0);
        chk("idle_busy", 64'(busy[i]), 64'd0);
        chk("pos_hold", 64'(pos[i]), 64'(gr * gr));
        chk("done_count", 64'(done_cnt - base_done), 64'd1);
        if (start_done) begin
            repeat (4) @(negedge wclk);
            chk("start_at_done", 64'({busy[i], rd[i]}), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        seed = int'($urandom);
        rst = 1'b1;
        start = '0;
        out_ready = '1;
        ovr[12840] = 16'hF800;
        ovr[12841] = 16'h07E0;
        ovr[13160] = 16'h001F;
        ovr[13161] = 16'hFFFF;
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        for (int i = 0; i < NI; i++)
            chk("reset_state", 64'({busy[i], sel[i], we[i], rd[i], addr[i], valid[i],
                                    rgb[i], pos[i], done[i]}), 64'd0);
        @(posedge wclk); #1 rst = 1'b0;

        run_pass(0, 5, 0, 1'b1, 1'b0, 1'b0);
        run_pass(0, 0, 4, 1'b0, 1'b0, 1'b0);
        run_pass(0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_pass(1, 0, 0, 1'b0, 1'b0, 1'b0);
        run_pass(2, 0, 0, 1'b0, 1'b0, 1'b1);
        run_pass(3, 0, 0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
